instruction_phase_sequencer: RTL
================================

INSTRUCTION_PHASE_SEQUENCER -- requirements
Module: instruction_phase_sequencer

Interface
REQ-001 SHALL have parameter RESET_IR, default 16'h0000, value loaded into the instruction register on reset.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 SHALL have port DIN  input  16  memory data bus, holding the instruction word during FETCH.
REQ-005 SHALL have port READY  input  1  memory ready; low requests a wait state.
REQ-006 SHALL have port HALT_REQ  input  1  request to stop at the next instruction boundary.
REQ-007 SHALL have ports FETCH, DECODE, EXECUTE, COMMIT  output  1 each  registered phase strobes.
REQ-008 SHALL have port FETCH_RD  output  1  memory read strobe for the instruction fetch; equals FETCH.
REQ-009 SHALL have port HALTED  output  1  registered, high while the sequencer is parked.
REQ-010 SHALL have port IR  output  16  latched instruction word.
REQ-011 SHALL have ports GROUPF[15:14], SKIPF[13:12], CCF[11:10], JPF[9:8]  output  2 each  instruction fields.
REQ-012 SHALL have ports JLF[7]  output  1 and ARGB[3:0]  output  4  instruction fields.
REQ-013 SHALL have port INSTR_COUNT  output  16  count of retired instructions.

Function
REQ-014 SHALL implement the states IDLE, FETCH, DECODE, EXECUTE, COMMIT and HALT, in one-hot or binary encoding.
REQ-015 SHALL assert exactly one of FETCH/DECODE/EXECUTE/COMMIT in the state of the same name, and none in IDLE or HALT.
REQ-016 SHALL move IDLE->FETCH on the next cycle when HALT_REQ=0, and IDLE->HALT when HALT_REQ=1.
REQ-017 SHALL latch DIN into IR on the final FETCH cycle, so that IR is valid from the first DECODE cycle.
REQ-018 SHALL move FETCH->DECODE->EXECUTE->COMMIT with one cycle per phase; nominal instruction = 4 cycles.
REQ-019 SHALL move COMMIT->HALT when HALT_REQ=1 is sampled in COMMIT, and COMMIT->FETCH otherwise.
REQ-020 SHALL ignore HALT_REQ in FETCH, DECODE and EXECUTE; an instruction in flight always completes.
REQ-021 SHALL hold the HALT state while HALT_REQ=1, with HALTED=1 and IR unchanged.
REQ-022 SHALL move HALT->FETCH on the cycle after HALT_REQ is sampled 0, with HALTED=0 in that FETCH cycle.
REQ-023 SHALL decode the field outputs combinationally from IR at the bit positions given in REQ-011/REQ-012; IR[6:4] is unused.
REQ-024 SHALL increment INSTR_COUNT by 1 on each COMMIT cycle, wrapping modulo 2^16 (16'hFFFF->16'h0000).
REQ-025 SHALL keep INSTR_COUNT and IR unchanged in every state other than those updating them in REQ-017 and REQ-024.

Reset
REQ-026 SHALL, when RESET=1 at a rising edge, enter IDLE regardless of current state, including mid-FETCH or mid-wait.
REQ-027 SHALL drive, one cycle after a reset edge: FETCH=DECODE=EXECUTE=COMMIT=FETCH_RD=0, HALTED=0, IR=RESET_IR, INSTR_COUNT=0.
REQ-028 SHALL give RESET priority over HALT_REQ and READY.

Configuration
REQ-029 SHALL support wait states when the macro SEQ_WAIT_STATE_EN is defined: FETCH and EXECUTE are held while READY=0, and a phase advances only on a cycle with READY=1.
REQ-030 SHALL, with SEQ_WAIT_STATE_EN defined, latch IR only on a FETCH cycle with READY=1, while keeping FETCH_RD asserted throughout.
REQ-031 SHALL, without SEQ_WAIT_STATE_EN, keep the READY port but ignore it, so that every phase lasts exactly one cycle.

Verification
REQ-032 SHALL cover: reset, then DIN=16'hA5C3 held, READY=1 -> FETCH at cycle 1, IR=16'hA5C3 at DECODE, GROUPF=2, SKIPF=2, CCF=1, JPF=1, JLF=1, ARGB=3.
REQ-033 SHALL cover: 3 back-to-back instructions -> strobe pattern F,D,E,C repeated with no gaps, INSTR_COUNT=3 after the third COMMIT.
REQ-034 SHALL cover: HALT_REQ raised during EXECUTE -> COMMIT completes, then HALTED=1; HALT_REQ dropped -> FETCH one cycle later.
REQ-035 SHALL cover: with SEQ_WAIT_STATE_EN, READY=0 for 2 cycles in FETCH -> FETCH lasts 3 cycles, and IR is taken from DIN on the READY=1 cycle only.
REQ-036 SHALL cover: RESET pulsed during DECODE after INSTR_COUNT=16'hFFFF -> IDLE, INSTR_COUNT=0, IR=RESET_IR; separately, a wrap test where 16'hFFFF->16'h0000 on COMMIT.

Source files
------------

// File: rtl/instruction_phase_sequencer.sv
// Instruction phase sequencer: IDLE/FETCH/DECODE/EXECUTE/COMMIT/HALT with IR latch and retire counter.
// Optional macro SEQ_WAIT_STATE_EN: READY=0 stretches FETCH and EXECUTE.
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | out of reset, decides between first fetch and halt
// FETCH   | instruction read on DIN, IR loaded on the final cycle
// DECODE  | IR valid, fields decoded
// EXECUTE | instruction executes
// COMMIT  | instruction retires, INSTR_COUNT increments
// HALT    | parked at an instruction boundary while HALT_REQ=1
module instruction_phase_sequencer #(
  parameter logic [15:0] RESET_IR = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] DIN,
  input  logic        READY,
  input  logic        HALT_REQ,
  output logic        FETCH,
  output logic        DECODE,
  output logic        EXECUTE,
  output logic        COMMIT,
  output logic        FETCH_RD,
  output logic        HALTED,
  output logic [15:0] IR,
  output logic [1:0]  GROUPF,
  output logic [1:0]  SKIPF,
  output logic [1:0]  CCF,
  output logic [1:0]  JPF,
  output logic        JLF,
  output logic [3:0]  ARGB,
  output logic [15:0] INSTR_COUNT
);

  // One-hot so every phase strobe is a flop output with no decode logic behind it
  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_FETCH   = 6'b000010,
    S_DECODE  = 6'b000100,
    S_EXECUTE = 6'b001000,
    S_COMMIT  = 6'b010000,
    S_HALT    = 6'b100000
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] count_q;
  logic        ir_load;
  logic        count_inc;
  logic        phase_ready;

`ifdef SEQ_WAIT_STATE_EN
  assign phase_ready = READY;
`else
  logic unused_ready;
  assign unused_ready = READY;
  assign phase_ready  = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    count_inc = 1'b0;
    case (state_q)
      S_IDLE:    state_d = HALT_REQ ? S_HALT : S_FETCH;
      S_FETCH: begin
        if (phase_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: if (phase_ready) state_d = S_COMMIT;
      S_COMMIT: begin
        count_inc = 1'b1;
        state_d   = HALT_REQ ? S_HALT : S_FETCH;
      end
      S_HALT:    if (!HALT_REQ) state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ir_q    <= RESET_IR;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= DIN;
      if (count_inc) count_q <= count_q + 16'h0001;
    end
  end

  assign FETCH       = state_q[1];
  assign DECODE      = state_q[2];
  assign EXECUTE     = state_q[3];
  assign COMMIT      = state_q[4];
  assign HALTED      = state_q[5];
  assign FETCH_RD    = state_q[1];
  assign IR          = ir_q;
  assign INSTR_COUNT = count_q;

  // IR[6:4] carries no field
  assign GROUPF = ir_q[15:14];
  assign SKIPF  = ir_q[13:12];
  assign CCF    = ir_q[11:10];
  assign JPF    = ir_q[9:8];
  assign JLF    = ir_q[7];
  assign ARGB   = ir_q[3:0];

endmodule
